// File: rtl/fifo72_frame_mux.sv
// fifo72_frame_mux
//   Frame-granular 2:1 merger. Whole frames are pulled from two
//   standard-read RX FIFOs (1-cycle read latency) and written unbroken
//   into a single TX FIFO. Arbitration is round-robin, one frame at a
//   time. Per-port forwarded-frame counters are kept.
//
//   Word format: [71:64] lane-valid mask, [63:0] data. Any mask other
//   than 8'hFF marks the last word of a frame (8'h00 is a pure
//   terminator and is forwarded like any other word).
//
// Ports
//   sys_clk              clock for all logic
//   sys_rst              synchronous reset, active low
//   rx0_dout/rx0_empty   port-0 RX FIFO read data / empty flag
//   rx0_rd_en            port-0 RX FIFO read strobe
//   rx1_dout/rx1_empty   port-1 RX FIFO read data / empty flag
//   rx1_rd_en            port-1 RX FIFO read strobe
//   tx_din/tx_wr_en      TX FIFO write data / write strobe
//   tx_full              TX FIFO full flag
//   busy                 high while a frame transfer is in progress
//   frm_cnt0/frm_cnt1    frames forwarded from port 0 / port 1 (wrapping)

module fifo72_frame_mux #(
  parameter int CntWidth = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [71:0]         rx0_dout,
  input  logic                rx0_empty,
  output logic                rx0_rd_en,
  input  logic [71:0]         rx1_dout,
  input  logic                rx1_empty,
  output logic                rx1_rd_en,
  output logic [71:0]         tx_din,
  input  logic                tx_full,
  output logic                tx_wr_en,
  output logic                busy,
  output logic [CntWidth-1:0] frm_cnt0,
  output logic [CntWidth-1:0] frm_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t              state_q;
  logic                sel_q;
  logic                last_grant_q;
  logic                rd_q;
  logic                skid_v_q;
  logic [71:0]         skid_q;
  logic                eof_pend_q;
  logic [71:0]         tx_hold_q;
  logic [CntWidth-1:0] cnt0_q;
  logic [CntWidth-1:0] cnt1_q;

  logic [71:0] cur_dout;
  logic        cur_empty;
  logic        grant;
  logic        arr_eof;
  logic        rd_go;
  logic        wr_skid;
  logic        wr_arr;
  logic [71:0] wr_data;
  logic        wr_eof;

  assign cur_dout  = sel_q ? rx1_dout  : rx0_dout;
  assign cur_empty = sel_q ? rx1_empty : rx0_empty;

  // Both requesting: take the port that did not win last time.
  // Otherwise the single requester wins (port 1 only when port 0 is empty).
  assign grant = (!rx0_empty && !rx1_empty) ? !last_grant_q : rx0_empty;

  // The word arriving this cycle is already visible, so its end-of-frame
  // mask blocks the next read in the same cycle; without this the read
  // issued alongside the eof arrival would pull the next frame's first word.
  assign arr_eof = rd_q && (cur_dout[71:64] != 8'hFF);

  // At most one word in flight plus one in skid: a read is only issued
  // when the TX side can take the word that is already arriving.
  assign rd_go = (state_q == XFER) && !cur_empty && !tx_full &&
                 !skid_v_q && !eof_pend_q && !arr_eof;

  assign rx0_rd_en = rd_go && !sel_q;
  assign rx1_rd_en = rd_go &&  sel_q;

  // Skid and arrival never coincide: reads stop while skid is loaded and
  // the word that loaded it was the only one in flight. The write decision
  // is made in the same cycle as tx_full is seen, so a full TX FIFO is
  // never overrun.
  assign wr_skid  = skid_v_q && !tx_full;
  assign wr_arr   = rd_q && !tx_full;
  assign tx_wr_en = wr_skid || wr_arr;
  assign wr_data  = skid_v_q ? skid_q : cur_dout;
  assign tx_din   = tx_wr_en ? wr_data : tx_hold_q;
  assign wr_eof   = tx_wr_en && (wr_data[71:64] != 8'hFF);

  assign busy     = (state_q != IDLE);
  assign frm_cnt0 = cnt0_q;
  assign frm_cnt1 = cnt1_q;

  // Frame FSM plus all datapath state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rd_q         <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_q       <= '0;
      eof_pend_q   <= 1'b0;
      tx_hold_q    <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      rd_q <= rd_go;
      if (tx_wr_en) begin
        tx_hold_q <= wr_data;
      end
      case (state_q)
        IDLE: begin
          if (!rx0_empty || !rx1_empty) begin
            sel_q        <= grant;
            last_grant_q <= grant;
            state_q      <= XFER;
          end
        end
        XFER: begin
          if (rd_q && tx_full) begin
            skid_v_q <= 1'b1;
            skid_q   <= cur_dout;
          end else if (wr_skid) begin
            skid_v_q <= 1'b0;
          end
          if (arr_eof) begin
            eof_pend_q <= 1'b1;
          end
          if (wr_eof) begin
            state_q <= LAST;
          end
        end
        LAST: begin
          if (sel_q) begin
            cnt1_q <= cnt1_q + CntWidth'(1);
          end else begin
            cnt0_q <= cnt0_q + CntWidth'(1);
          end
          eof_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
